// File: rtl/matrix_result_writer_if.sv
// matrix_result_writer_if: producer handshake, element stream and BRAM write port of the result writer
interface matrix_result_writer_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
);
  logic                  write_request;
  logic                  write_ready;
  logic [2:0]            matrix_id;
  logic [7:0]            actual_rows;
  logic [7:0]            actual_cols;
  logic [7:0]            matrix_name [0:7];
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  writer_ready;
  logic                  write_done;
  logic                  write_err;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  modport master (
    output write_request, matrix_id, actual_rows, actual_cols, matrix_name, data_in, data_valid,
    input  write_ready, writer_ready, write_done, write_err, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  write_request, matrix_id, actual_rows, actual_cols, matrix_name, data_in, data_valid,
    output write_ready, writer_ready, write_done, write_err, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/matrix_result_writer.sv
// matrix_result_writer: writes metadata plus a row-major element stream into a BRAM slot; MATRIX_WRITER_ZERO_FILL_EN adds zero fill of the unused slot tail
`ifndef MATRIX_BLOCK_SIZE
`define MATRIX_BLOCK_SIZE 64
`endif
`ifndef MATRIX_ADDR_WIDTH
`define MATRIX_ADDR_WIDTH 9
`endif
`ifndef MATRIX_METADATA_WORDS
`define MATRIX_METADATA_WORDS 4
`endif
module matrix_result_writer #(
  parameter int BLOCK_SIZE = `MATRIX_BLOCK_SIZE,
  parameter int ADDR_WIDTH = `MATRIX_ADDR_WIDTH,
  parameter int DATA_WIDTH = 32,
  parameter int META_WORDS = `MATRIX_METADATA_WORDS
) (
  input logic clk,
  input logic rst_n,
  matrix_result_writer_if.slave bus
);
  localparam int CAP = BLOCK_SIZE - META_WORDS;
`ifdef MATRIX_WRITER_ZERO_FILL_EN
  typedef enum logic [2:0] {IDLE, WRITE_META, ACCEPT_DATA, ZERO_FILL, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, WRITE_META, ACCEPT_DATA, DONE} state_t;
`endif
  state_t state, nxt;
  logic [15:0] cnt, total, off, req_total;
  logic [7:0] rows, cols;
  logic [7:0][7:0] name;
  logic [ADDR_WIDTH-1:0] base;
  logic [DATA_WIDTH-1:0] meta, wdata;
  logic req_err, accept, last_meta, last_beat, wr, zf;
  assign req_total = 16'(bus.actual_rows) * 16'(bus.actual_cols);
  assign req_err = 32'(bus.matrix_id) >= 32'd8 || 32'(req_total) > 32'(CAP);
  assign accept = state == ACCEPT_DATA && bus.data_valid;
  assign last_meta = cnt == 16'(META_WORDS - 1);
  assign last_beat = cnt == total - 16'd1;
`ifdef MATRIX_WRITER_ZERO_FILL_EN
  assign zf = state == ZERO_FILL;
`else
  assign zf = 1'b0;
`endif
  assign wr = state == WRITE_META || accept || zf;
  assign off = state == WRITE_META ? cnt : 16'(META_WORDS) + cnt;
  assign meta = cnt == 16'd0 ? DATA_WIDTH'({cols, rows}) :
                cnt == 16'd1 ? DATA_WIDTH'(name[3:0]) :
                cnt == 16'd2 ? DATA_WIDTH'(name[7:4]) : '0;
  assign wdata = state == WRITE_META ? meta : zf ? '0 : bus.data_in;
  assign bus.write_ready = state == IDLE;
  assign bus.writer_ready = state == ACCEPT_DATA;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next-state: metadata, then data beats, then optional tail fill, then one DONE cycle
  always_comb begin
    nxt = state;
    case (state)
      IDLE:        nxt = !bus.write_request ? IDLE : req_err ? DONE : WRITE_META;
      WRITE_META:  nxt = !last_meta ? WRITE_META : total != 16'd0 ? ACCEPT_DATA : DONE;
      ACCEPT_DATA: nxt = !(accept && last_beat) ? ACCEPT_DATA :
`ifdef MATRIX_WRITER_ZERO_FILL_EN
                         32'(total) < 32'(CAP) ? ZERO_FILL :
`endif
                         DONE;
`ifdef MATRIX_WRITER_ZERO_FILL_EN
      ZERO_FILL:   nxt = cnt == 16'(CAP - 1) ? DONE : ZERO_FILL;
`endif
      DONE:        nxt = IDLE;
      default:     nxt = IDLE;
    endcase
  end
  // request latch, beat/word counter and registered BRAM port; cnt keeps counting past the last beat to address the tail fill
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      total <= '0;
      rows <= '0;
      cols <= '0;
      name <= '0;
      base <= '0;
      bus.write_err <= 1'b0;
      bus.write_done <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
    end else begin
      cnt <= state == IDLE || state == DONE || (state == WRITE_META && last_meta) ? '0 : wr ? cnt + 16'd1 : cnt;
      bus.write_done <= state == DONE;
      bus.mem_we <= wr;
      if (wr) begin
        bus.mem_addr <= base + ADDR_WIDTH'(off);
        bus.mem_wdata <= wdata;
      end
      if (state == IDLE && bus.write_request) begin
        base <= ADDR_WIDTH'(32'(bus.matrix_id) * 32'(BLOCK_SIZE));
        rows <= bus.actual_rows;
        cols <= bus.actual_cols;
        total <= req_total;
        bus.write_err <= req_err;
        for (int i = 0; i < 8; i++) name[i] <= bus.matrix_name[i];
      end
    end
endmodule

// File: tb/tb_matrix_result_writer.sv
// tb_matrix_result_writer: randomized transfers checked against a queue of expected BRAM writes built from the slot layout rules
module tb_matrix_result_writer;
  localparam int BS = 16;
  localparam int AW = 7;
  localparam int MW = 4;
  localparam int CAP = BS - MW;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_total = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int exp_base = 0;
  bit wr_seen = 1'b0;
  bit prev_done = 1'b0;
  logic [38:0] q [$];
  logic [31:0] mem [0:127];
  logic [31:0] lit [10];
  matrix_result_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();
  matrix_result_writer #(.BLOCK_SIZE(BS), .ADDR_WIDTH(AW), .DATA_WIDTH(32), .META_WORDS(MW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic check_reset();
    check("rst_write_ready", 32'(bus.write_ready), 1);
    check("rst_writer_ready", 32'(bus.writer_ready), 0);
    check("rst_write_done", 32'(bus.write_done), 0);
    check("rst_write_err", 32'(bus.write_err), 0);
    check("rst_mem_we", 32'(bus.mem_we), 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
  endtask
  always @(posedge clk) begin
    #1;
    if (!rst_n) prev_done = 1'b0;
    else begin
      if (bus.writer_ready) wr_seen = 1'b1;
      if (bus.mem_we) begin
        logic [38:0] e;
        mem[bus.mem_addr] = bus.mem_wdata;
        check("addr_in_slot", 32'(int'(bus.mem_addr) >= exp_base && int'(bus.mem_addr) < exp_base + BS), 1);
        check("write_expected", 32'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("wr_addr", 32'(bus.mem_addr), 32'(e[38:32]));
          check("wr_data", bus.mem_wdata, e[31:0]);
        end
      end
      if (bus.write_done) begin
        check("done_single", 32'(prev_done), 0);
        check("done_after_writes", q.size(), 0);
        done_cnt++;
      end
      prev_done = bus.write_done;
    end
  end
  task automatic xfer(input int id, input int r, input int c, input logic [63:0] nm, input int mode, input bit poke, input bit seq, input int rst_at);
    int tot, k, n, d0, b;
    bit err, poked;
    logic [31:0] beats [$];
    tot = r * c;
    err = tot > CAP;
    b = id * BS;
    for (int i = 0; i < tot; i++) beats.push_back(seq ? 32'(i + 1) : $urandom);
    if (!err) begin
      q.push_back({7'(b), 32'((c << 8) | r)});
      q.push_back({7'(b + 1), nm[31:0]});
      q.push_back({7'(b + 2), nm[63:32]});
      for (int i = 3; i < MW; i++) q.push_back({7'(b + i), 32'd0});
      for (int i = 0; i < tot; i++) q.push_back({7'(b + MW + i), beats[i]});
`ifdef MATRIX_WRITER_ZERO_FILL_EN
      if (tot > 0) for (int i = MW + tot; i < BS; i++) q.push_back({7'(b + i), 32'd0});
`endif
    end
    exp_base = b;
    d0 = done_cnt;
    @(negedge clk);
    bus.write_request = 1'b1;
    bus.matrix_id = 3'(id);
    bus.actual_rows = 8'(r);
    bus.actual_cols = 8'(c);
    for (int i = 0; i < 8; i++) bus.matrix_name[i] = nm[8*i +: 8];
    @(negedge clk);
    bus.write_request = 1'b0;
    bus.matrix_id = 3'($urandom);
    bus.actual_rows = 8'($urandom);
    bus.actual_cols = 8'($urandom);
    for (int i = 0; i < 8; i++) bus.matrix_name[i] = 8'($urandom);
    wr_seen = 1'b0;
    k = 0;
    n = 0;
    poked = 1'b0;
    while (k < tot && !err && n < 300) begin
      bit v;
      if (rst_at > 0 && k == rst_at) begin
        rst_n = 1'b0;
        bus.data_valid = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        check_reset();
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      v = mode == 0 ? 1'b1 : mode == 1 ? n[0] : 1'($urandom_range(0, 1));
      bus.data_valid = v;
      bus.data_in = v ? beats[k] : $urandom;
      bus.write_request = poke && !poked && k == 2 && bus.writer_ready;
      if (bus.write_request) begin
        poked = 1'b1;
        bus.matrix_id = 3'($urandom);
      end
      if (v && bus.writer_ready) k++;
      n++;
      @(negedge clk);
    end
    bus.write_request = 1'b0;
    if (!err) check("beats_taken", k, tot);
    n = 0;
    while (done_cnt == d0 && n < 100) begin
      bus.data_valid = 1'($urandom_range(0, 1));
      bus.data_in = $urandom;
      n++;
      @(negedge clk);
    end
    bus.data_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("done_count", done_cnt - d0, 1);
    check("write_err", 32'(bus.write_err), 32'(err));
    check("writes_drained", q.size(), 0);
    check("idle_after", 32'(bus.write_ready), 1);
    if (err || tot == 0) check("writer_ready_quiet", 32'(wr_seen), 0);
    q.delete();
  endtask
  initial begin
    #500000;
    $display("FAIL timeout: run did not reach its end");
    $fatal(1);
  end
  initial begin
    logic [63:0] scal;
    scal = 64'h0053_4552_4C41_4353;
    lit = '{32'h0000_0302, 32'h4C41_4353, 32'h0053_4552, 32'h0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    for (int i = 0; i < 128; i++) mem[i] = 32'hDEAD_BEEF;
    bus.write_request = 1'b0;
    bus.matrix_id = '0;
    bus.actual_rows = '0;
    bus.actual_cols = '0;
    for (int i = 0; i < 8; i++) bus.matrix_name[i] = '0;
    bus.data_in = '0;
    bus.data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;
    xfer(2, 2, 3, scal, 0, 1'b0, 1'b1, 0);
    for (int i = 0; i < 10; i++) check("slot2_word", mem[32 + i], lit[i]);
    xfer(3, 2, 3, scal, 1, 1'b0, 1'b1, 0);
    for (int i = 0; i < 10; i++) check("slot3_word", mem[48 + i], lit[i]);
    xfer(4, 0, 5, 64'h0102_0304_0506_0708, 0, 1'b0, 1'b0, 0);
    check("rows0_meta", mem[64], 32'h0000_0500);
    xfer(7, 13, 1, 64'h1122_3344_5566_7788, 2, 1'b0, 1'b0, 0);
    xfer(0, 3, 4, {$urandom, $urandom}, 2, 1'b1, 1'b0, 0);
    xfer(1, 2, 3, {$urandom, $urandom}, 0, 1'b0, 1'b0, 3);
    xfer(6, 2, 2, {$urandom, $urandom}, 0, 1'b0, 1'b0, 0);
    check("after_reset_data", 32'(mem[96]), 32'h0000_0202);
`ifdef MATRIX_WRITER_ZERO_FILL_EN
    xfer(5, 1, 1, {$urandom, $urandom}, 0, 1'b0, 1'b0, 0);
    for (int i = MW + 1; i < BS; i++) check("zero_fill_word", mem[80 + i], 32'h0);
`endif
    for (int t = 0; t < 20; t++)
      xfer($urandom_range(0, 7), $urandom_range(0, 5), $urandom_range(0, 5), {$urandom, $urandom},
           $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/matrix_result_writer.md
MATRIX_RESULT_WRITER -- requirements
Module: matrix_result_writer

Interface
REQ-001 The block SHALL have parameters: BLOCK_SIZE, default MATRIX_BLOCK_SIZE, words per matrix slot; ADDR_WIDTH, default MATRIX_ADDR_WIDTH, address width; DATA_WIDTH, default 32, word width; META_WORDS, default MATRIX_METADATA_WORDS (at least 3), metadata words per slot.
REQ-002 clk  in  1  clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 write_request  in  1  one-cycle start pulse from the producer.
REQ-005 write_ready  out  1  high while the block is in IDLE and a request can be taken.
REQ-006 matrix_id  in  3  destination slot.
REQ-007 actual_rows  in  8  row count of the result.
REQ-008 actual_cols  in  8  column count of the result.
REQ-009 matrix_name  in  8x8  name bytes [0:7].
REQ-010 data_in  in  DATA_WIDTH  element word, row-major.
REQ-011 data_valid  in  1  data_in valid.
REQ-012 writer_ready  out  1  level signal: the block accepts element beats.
REQ-013 write_done  out  1  one-cycle completion pulse.
REQ-014 write_err  out  1  sticky error flag; cleared on the next accepted request.
REQ-015 mem_we  out  1  BRAM write enable.
REQ-016 mem_addr  out  ADDR_WIDTH  BRAM address.
REQ-017 mem_wdata  out  DATA_WIDTH  BRAM write data.

Function
REQ-018 The state machine SHALL have the states IDLE, WRITE_META, ACCEPT_DATA, ZERO_FILL, DONE.
REQ-019 In IDLE, write_request SHALL latch matrix_id, rows, cols and name, and compute total = rows*cols (16 bit) and base = matrix_id*BLOCK_SIZE.
REQ-020 A write_request seen outside IDLE SHALL be ignored.
REQ-021 Error check at latch time: if matrix_id >= 8, or total > BLOCK_SIZE-META_WORDS, the block SHALL set write_err, write nothing, and go to DONE.
REQ-022 WRITE_META SHALL write META_WORDS consecutive words from base, one per cycle:
- word0 = {zero, cols[15:8], rows[7:0]};
- word1 = name[3..0] (name[0] in bits [7:0]);
- word2 = name[7..4];
- all further words = 0.
REQ-023 After the last metadata word, the block SHALL go to ACCEPT_DATA if total > 0, otherwise to DONE.
REQ-024 writer_ready SHALL be 1 only in ACCEPT_DATA.
REQ-025 A beat SHALL be accepted on any cycle where data_valid and writer_ready are both high; beat k SHALL be written to base+META_WORDS+k.
REQ-026 data_valid while writer_ready is low SHALL be ignored.
REQ-027 mem_we, mem_addr and mem_wdata SHALL be registered; each write appears on the cycle after the state/beat that produces it.
REQ-028 After beat total-1 is accepted, writer_ready SHALL drop on the next cycle, and the state SHALL go to ZERO_FILL (macro defined) or DONE.
REQ-029 DONE SHALL pulse write_done for exactly one cycle, on the cycle after the final mem_we, then return to IDLE.
REQ-030 The write address SHALL never leave [base, base+BLOCK_SIZE-1].
REQ-031 The beat counter SHALL be 16 bit, and total = 0xFFFF SHALL not wrap the counter.

Reset
REQ-032 On reset, including mid-operation, the block SHALL enter IDLE and set write_ready=1, writer_ready=0, write_done=0, write_err=0, mem_we=0, mem_addr=0, mem_wdata=0, and clear all latches and counters; a partially written slot SHALL be left as is.

Configuration
REQ-033 Macro MATRIX_WRITER_ZERO_FILL_EN:
- defined: ZERO_FILL writes 0 to base+META_WORDS+total through base+BLOCK_SIZE-1, one word per cycle, before DONE; ZERO_FILL is skipped if total fills the slot.
- undefined: the ZERO_FILL state and its logic are absent, and ACCEPT_DATA goes straight to DONE.

Verification
REQ-034 id=2, 2x3, name "SCALRES", six beats 1..6 with data_valid held high -> metadata at base 2*BLOCK_SIZE, data words 1..6 at base+META_WORDS..+5, one write_done pulse, write_err=0.
REQ-035 Same transfer with data_valid toggling every other cycle -> identical memory contents, and no beat dropped or duplicated.
REQ-036 rows=0 -> only metadata is written, writer_ready never rises, write_done pulses.
REQ-037 total = BLOCK_SIZE-META_WORDS+1 -> write_err=1, mem_we never asserted, write_done pulses.
REQ-038 write_request pulsed during ACCEPT_DATA -> ignored; rst_n low mid-data -> all outputs at reset values next cycle, and a new request then completes normally.
REQ-039 With MATRIX_WRITER_ZERO_FILL_EN and a 1x1 transfer -> the remaining BLOCK_SIZE-META_WORDS-1 words are written 0 before write_done.
